// File: rtl/shader_spi_pkg.sv
// shader_spi_pkg: shared types and constants for the shader SPI host
package shader_spi_pkg;
  localparam int SPI_BYTE_W = 8;
  localparam int SPI_BIT_CNT_W = 3;
  localparam logic SPI_CS_ACTIVE = 1'b0;
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, WAIT, HOLD, GAP} spi_state_e;
endpackage

// File: rtl/shader_spi_clkgen.sv
// shader_spi_clkgen: H-cycle phase counter, ticks when a phase has lasted CLK_DIV cycles
module shader_spi_clkgen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic reload,
  output logic phase_tick
);
  localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);
  logic [7:0] cnt_q, cnt_d;
  assign phase_tick = en && (cnt_q == 8'd0);
  // restart the phase on any state change or completed phase, otherwise count down
  always_comb begin
    cnt_d = (reload || phase_tick) ? RELOAD : en ? cnt_q - 8'd1 : cnt_q;
  end
  // counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= RELOAD;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/shader_spi_host.sv
// shader_spi_host: mode-0 MSB-first SPI host; SHADER_SPI_HOST_RX_EN enables MISO capture
module shader_spi_host #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       spi_cs,
  output logic       spi_sclk,
  output logic       spi_mosi,
  input  logic       spi_miso
);
  import shader_spi_pkg::*;
  spi_state_e state_q, state_d;
  logic [SPI_BYTE_W-1:0] tx_q, tx_d;
  logic [SPI_BIT_CNT_W-1:0] bit_q, bit_d;
  logic last_q, last_d, sclk_q, sclk_d, cs_q, cs_d, ready_q, ready_d, tick, hs;
  assign hs = tx_valid && ready_q;
  shader_spi_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .clk(clk),
    .rst_n(rst_n),
    .en(!(state_q inside {IDLE, WAIT})),
    .reload(state_d != state_q),
    .phase_tick(tick)
  );
  // next-state, TX shifter, bit counter and registered SPI pin values
  always_comb begin
    state_d = state_q;
    tx_d = tx_q;
    last_d = last_q;
    bit_d = bit_q;
    sclk_d = sclk_q;
    case (state_q)
      IDLE, WAIT: if (hs) begin
        state_d = SETUP;
        tx_d = tx_data;
        last_d = tx_last;
        bit_d = '0;
      end
      SETUP: state_d = tick ? SHIFT : SETUP;
      SHIFT: if (tick) begin
        sclk_d = !sclk_q;
        if (sclk_q) begin
          tx_d = {tx_q[SPI_BYTE_W-2:0], 1'b0};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = last_q ? HOLD : WAIT;
        end
      end
      HOLD: state_d = tick ? GAP : HOLD;
      GAP: state_d = tick ? IDLE : GAP;
      default: state_d = IDLE;
    endcase
    cs_d = (state_d inside {IDLE, GAP}) ? ~SPI_CS_ACTIVE : SPI_CS_ACTIVE;
    ready_d = state_d inside {IDLE, WAIT};
  end
  // FSM and datapath registers; ready is registered so it is low while in reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tx_q <= '0;
      last_q <= 1'b0;
      bit_q <= '0;
      sclk_q <= 1'b0;
      cs_q <= ~SPI_CS_ACTIVE;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q <= tx_d;
      last_q <= last_d;
      bit_q <= bit_d;
      sclk_q <= sclk_d;
      cs_q <= cs_d;
      ready_q <= ready_d;
    end
  end
  assign tx_ready = ready_q;
  assign busy = state_q != IDLE;
  assign spi_cs = cs_q;
  assign spi_sclk = sclk_q;
  assign spi_mosi = tx_q[SPI_BYTE_W-1];
`ifdef SHADER_SPI_HOST_RX_EN
  logic [SPI_BYTE_W-1:0] rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
  logic rx_valid_q, rx_valid_d, sample;
  assign sample = tick && state_q == SHIFT && !sclk_q;
  // sample MISO on each rise; publish the byte on the 8th fall
  always_comb begin
    rx_valid_d = tick && state_q == SHIFT && sclk_q && bit_q == 3'd7;
    rx_sh_d = sample ? {rx_sh_q[SPI_BYTE_W-2:0], spi_miso} : rx_sh_q;
    rx_data_d = rx_valid_d ? rx_sh_q : rx_data_q;
  end
  // capture registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sh_q <= '0;
      rx_data_q <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_sh_q <= rx_sh_d;
      rx_data_q <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end
  assign rx_data = rx_data_q;
  assign rx_valid = rx_valid_q;
`else
  logic unused_miso;
  assign unused_miso = spi_miso;
  assign rx_data = '0;
  assign rx_valid = 1'b0;
`endif
endmodule

// File: tb/tb_shader_spi_host.sv
// tb_shader_spi_host: directed self-checking bench for shader_spi_host (CLK_DIV=2 and CLK_DIV=1)
`timescale 1ns/1ps
module tb_shader_spi_host;
`ifdef SHADER_SPI_HOST_RX_EN
  localparam bit RX = 1'b1;
`else
  localparam bit RX = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [7:0] tx_data0 = 8'h00, tx_data1 = 8'h00, rx_data0, rx_data1, pat0 = 8'h00, mlog0 = 8'h00;
  logic tx_last0 = 1'b0, tx_last1 = 1'b0, tx_valid0 = 1'b0, tx_valid1 = 1'b0;
  logic tx_ready0, tx_ready1, rx_valid0, rx_valid1, busy0, busy1;
  logic cs0, cs1, sclk0, sclk1, mosi0, mosi1, miso0, miso1, loop0 = 1'b1;
  int unsigned fall0 = 0, fall_base0 = 0, rise0 = 0, csw0 = 0, cslow0 = 0, rxv0 = 0, rxv1 = 0;
  int unsigned hi1 = 0, last_hi1 = 0, vec = 0, errs = 0;
  longint last_t1 = 0, per1 = 0;
  logic [2:0] idx0;
  assign idx0 = 3'(fall0 - fall_base0);
  assign miso0 = loop0 ? mosi0 : pat0[~idx0];
  assign miso1 = mosi1;

  shader_spi_host #(.CLK_DIV(2)) u0 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data0), .tx_last(tx_last0), .tx_valid(tx_valid0),
    .tx_ready(tx_ready0), .rx_data(rx_data0), .rx_valid(rx_valid0), .busy(busy0),
    .spi_cs(cs0), .spi_sclk(sclk0), .spi_mosi(mosi0), .spi_miso(miso0)
  );
  shader_spi_host #(.CLK_DIV(1)) u1 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data1), .tx_last(tx_last1), .tx_valid(tx_valid1),
    .tx_ready(tx_ready1), .rx_data(rx_data1), .rx_valid(rx_valid1), .busy(busy1),
    .spi_cs(cs1), .spi_sclk(sclk1), .spi_mosi(mosi1), .spi_miso(miso1)
  );

  always @(posedge sclk0) begin
    rise0++;
    mlog0 = {mlog0[6:0], mosi0};
  end
  always @(negedge sclk0) fall0++;
  always @(negedge cs0) csw0++;
  always @(posedge sclk1) begin
    per1 = $time - last_t1;
    last_t1 = $time;
  end
  always @(posedge clk) begin
    if (!cs0) cslow0++;
    if (rx_valid0) rxv0++;
    if (rx_valid1) rxv1++;
    if (cs1) hi1++;
    else begin
      if (hi1 != 0) last_hi1 = hi1;
      hi1 = 0;
    end
  end

  function automatic logic [7:0] rx_exp(input logic [7:0] v);
    return RX ? v : 8'h00;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send0(input logic [7:0] d, input logic l);
    logic ok;
    tx_data0 = d;
    tx_last0 = l;
    tx_valid0 = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 1000 && !ok; n++) begin
      @(posedge clk);
      ok = tx_ready0;
    end
    #1;
    chk("send0_handshake", ok, 1);
  endtask

  task automatic send1(input logic [7:0] d, input logic l);
    logic ok;
    tx_data1 = d;
    tx_last1 = l;
    tx_valid1 = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 1000 && !ok; n++) begin
      @(posedge clk);
      ok = tx_ready1;
    end
    #1;
    chk("send1_handshake", ok, 1);
  endtask

  task automatic wait_cs0(input string tag);
    logic ok;
    ok = 1'b0;
    for (int n = 0; n < 2000 && !ok; n++) begin
      @(negedge clk);
      ok = cs0;
    end
    chk(tag, ok, 1);
  endtask

  initial begin
    int unsigned b_rise, b_csw, b_low, b_rxv, b_fall, bad;
    logic ok;
    repeat (3) @(negedge clk);
    chk("rst_cs", cs0, 1);
    chk("rst_sclk", sclk0, 0);
    chk("rst_mosi", mosi0, 0);
    chk("rst_ready", tx_ready0, 0);
    chk("rst_rxv", rx_valid0, 0);
    chk("rst_rxdata", rx_data0, 8'h00);
    chk("rst_busy", busy0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    // single byte 0xA5, looped back
    b_low = cslow0;
    b_rxv = rxv0;
    send0(8'hA5, 1'b1);
    tx_valid0 = 1'b0;
    wait_cs0("t1_done");
    chk("t1_mosi", mlog0, 8'hA5);
    chk("t1_rxdata", rx_data0, rx_exp(8'hA5));
    chk("t1_rxv", rxv0 - b_rxv, RX ? 1 : 0);
    chk("t1_cs_low", cslow0 - b_low, 36);
    repeat (4) @(negedge clk);
    chk("t1_idle_busy", busy0, 0);
    // three-byte frame, valid held high
    b_rise = rise0;
    b_csw = csw0;
    b_rxv = rxv0;
    send0(8'h01, 1'b0);
    send0(8'h02, 1'b0);
    send0(8'h03, 1'b1);
    tx_valid0 = 1'b0;
    wait_cs0("t2_done");
    chk("t2_rises", rise0 - b_rise, 24);
    chk("t2_cs_windows", csw0 - b_csw, 1);
    chk("t2_rxv", rxv0 - b_rxv, RX ? 3 : 0);
    chk("t2_rxdata", rx_data0, rx_exp(8'h03));
    repeat (4) @(negedge clk);
    // stall between bytes
    b_fall = fall0;
    send0(8'h11, 1'b0);
    tx_valid0 = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 1000 && !ok; n++) begin
      @(negedge clk);
      ok = (fall0 - b_fall) >= 8;
    end
    chk("t3_first_byte", ok, 1);
    bad = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (cs0 !== 1'b0 || sclk0 !== 1'b0) bad++;
    end
    chk("t3_stall_hold", bad, 0);
    chk("t3_stall_ready", tx_ready0, 1);
    send0(8'h96, 1'b1);
    tx_valid0 = 1'b0;
    wait_cs0("t3_done");
    chk("t3_mosi", mlog0, 8'h96);
    chk("t3_rxdata", rx_data0, rx_exp(8'h96));
    repeat (4) @(negedge clk);
    // slave drives 0x3C while host sends 0xFF
    loop0 = 1'b0;
    pat0 = 8'h3C;
    fall_base0 = fall0;
    send0(8'hFF, 1'b1);
    tx_valid0 = 1'b0;
    wait_cs0("t4_done");
    chk("t4_mosi", mlog0, 8'hFF);
    chk("t4_rxdata", rx_data0, rx_exp(8'h3C));
    loop0 = 1'b1;
    repeat (4) @(negedge clk);
    // reset after the 4th rise
    b_rxv = rxv0;
    b_rise = rise0;
    send0(8'hF0, 1'b1);
    tx_valid0 = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 1000 && !ok; n++) begin
      @(negedge clk);
      ok = (rise0 - b_rise) >= 4;
    end
    chk("t5_four_rises", ok, 1);
    chk("t5_sclk_high", sclk0, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_cs_async", cs0, 1);
    chk("t5_sclk_async", sclk0, 0);
    chk("t5_busy_async", busy0, 0);
    chk("t5_ready_async", tx_ready0, 0);
    repeat (3) @(negedge clk);
    chk("t5_no_rxv", rxv0 - b_rxv, 0);
    rst_n = 1'b1;
    @(negedge clk);
    send0(8'h5A, 1'b1);
    tx_valid0 = 1'b0;
    wait_cs0("t5_done");
    chk("t5_mosi", mlog0, 8'h5A);
    chk("t5_rxdata", rx_data0, rx_exp(8'h5A));
    chk("t5_rxv", rxv0 - b_rxv, RX ? 1 : 0);
    // CLK_DIV=1, two back-to-back one-byte frames
    b_rxv = rxv1;
    send1(8'hC3, 1'b1);
    send1(8'h3C, 1'b1);
    tx_valid1 = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 1000 && !ok; n++) begin
      @(negedge clk);
      ok = cs1;
    end
    chk("t6_done", ok, 1);
    chk("t6_sclk_period", 32'(per1), 20);
    chk("t6_cs_gap_min", last_hi1 >= 2, 1);
    chk("t6_rxdata", rx_data1, rx_exp(8'h3C));
    chk("t6_rxv", rxv1 - b_rxv, RX ? 2 : 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
